// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic examples: FSM state encoding
// and the bit-counter width helper.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must hold N itself once the final bit has been consumed.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/fullsub1.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fullsub1 (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first: DIFF = A - B - B_IN (mod 2^N),
// one bit per clock through a single shared full-subtractor cell.
module serial_sub
   import arith_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         B_IN,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] DIFF,
   output logic         B_OUT
);

   localparam int CNT_W = cnt_width(N);

   state_t           state_q, state_d;
   logic [N-1:0]     a_sr_q, a_sr_d;
   logic [N-1:0]     b_sr_q, b_sr_d;
   logic [N-1:0]     d_sr_q, d_sr_d;
   logic [N-1:0]     diff_q, diff_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_d_s, bit_bout_s;
   logic             last_bit_s, accept_s;
   logic             ready_s, done_s;

   fullsub1 u_cell (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (br_q),
      .d    (bit_d_s),
      .bout (bit_bout_s)
   );

   assign last_bit_s = (cnt_q == CNT_W'(N - 1));
   assign accept_s   = start & ready_s;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start ? RUN : IDLE;
         RUN:     state_d = last_bit_s ? DONE : RUN;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ready_s = 1'b0;
      done_s  = 1'b0;
      case (state_q)
         IDLE:    ready_s = 1'b1;
         RUN:     ready_s = 1'b0;
         DONE: begin
            ready_s = 1'b1;
            done_s  = 1'b1;
         end
         default: ready_s = 1'b0;
      endcase
   end

   // Datapath next state: load on accepted start, shift one bit per RUN cycle
   always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      d_sr_d = d_sr_q;
      br_d   = br_q;
      cnt_d  = cnt_q;
      diff_d = diff_q;
      bout_d = bout_q;
      if (accept_s) begin
         a_sr_d = A;
         b_sr_d = B;
         br_d   = B_IN;
         cnt_d  = {CNT_W{1'b0}};
      end else if (state_q == RUN) begin
         a_sr_d         = a_sr_q >> 1;
         b_sr_d         = b_sr_q >> 1;
         d_sr_d         = d_sr_q >> 1;
         d_sr_d[N-1]    = bit_d_s;
         br_d           = bit_bout_s;
         cnt_d          = cnt_q + CNT_W'(1);
         // Publish on the edge that consumes the final bit.
         if (last_bit_s) begin
            diff_d = d_sr_d;
            bout_d = br_d;
         end else begin
            diff_d = diff_q;
            bout_d = bout_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr_q <= {N{1'b0}};
         b_sr_q <= {N{1'b0}};
         d_sr_q <= {N{1'b0}};
         br_q   <= 1'b0;
         cnt_q  <= {CNT_W{1'b0}};
         diff_q <= {N{1'b0}};
         bout_q <= 1'b0;
      end else begin
         a_sr_q <= a_sr_d;
         b_sr_q <= b_sr_d;
         d_sr_q <= d_sr_d;
         br_q   <= br_d;
         cnt_q  <= cnt_d;
         diff_q <= diff_d;
         bout_q <= bout_d;
      end
   end

   assign ready = ready_s;
   assign done  = done_s;
   assign DIFF  = diff_q;
   assign B_OUT = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (N=4): scoreboard of expected results
// pushed at launch and popped on each done pulse, plus latency/handshake checks.
module tb_serial_sub;

   localparam int N = 4;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [4:0] exp;
   } op_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] A;
   logic [3:0] B;
   logic       B_IN;
   logic       ready;
   logic       done;
   logic [3:0] DIFF;
   logic       B_OUT;

   int  checks_cnt;
   int  fail_cnt;
   op_t sb[$];

   serial_sub #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .B_IN  (B_IN),
      .ready (ready),
      .done  (done),
      .DIFF  (DIFF),
      .B_OUT (B_OUT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: compare every done pulse against the oldest launched operation
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("spurious_done", 32'd1, 32'd0);
         end else begin
            op_t        op;
            logic [3:0] sum;
            op  = sb.pop_front();
            sum = DIFF + op.b + {3'b000, op.bin};
            check_eq("result", {27'd0, B_OUT, DIFF}, {27'd0, op.exp});
            check_eq("adder", {28'd0, sum}, {28'd0, op.a});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a start (DUT expected ready) and record the expected result.
   task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic bin);
      op_t op;
      start  = 1'b1;
      A      = a;
      B      = b;
      B_IN   = bin;
      op.a   = a;
      op.b   = b;
      op.bin = bin;
      op.exp = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
      sb.push_back(op);
      tick();
      start = 1'b0;
      A     = $urandom_range(0, 15);
      B     = $urandom_range(0, 15);
      B_IN  = $urandom_range(0, 1);
   endtask

   // Step N edges after acceptance, checking ready/done timing; optionally
   // inject an ignored start at cycle 'intrude'.
   task automatic wait_done(input int intrude);
      for (int i = 1; i <= N; i++) begin
         start = 1'b0;
         tick();
         check_eq("ready_lat", {31'd0, ready}, (i == N) ? 32'd1 : 32'd0);
         check_eq("done_lat", {31'd0, done}, (i == N) ? 32'd1 : 32'd0);
         if (i == intrude) begin
            start = 1'b1;
            A     = 4'd1;
            B     = 4'd1;
            B_IN  = 1'b0;
         end
      end
   endtask

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin, input int intrude);
      launch(a, b, bin);
      wait_done(intrude);
   endtask

   initial begin
      checks_cnt = 0;
      fail_cnt   = 0;
      reset = 1'b1;
      start = 1'b0;
      A     = 4'd0;
      B     = 4'd0;
      B_IN  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("rst_ready", {31'd0, ready}, 32'd1);
         check_eq("rst_done", {31'd0, done}, 32'd0);
         check_eq("rst_diff", {28'd0, DIFF}, 32'd0);
         check_eq("rst_bout", {31'd0, B_OUT}, 32'd0);
      end

      run_op(4'd5, 4'd3, 1'b0, 0);
      tick();
      run_op(4'd3, 4'd5, 1'b0, 0);
      tick();
      check_eq("hold_diff", {28'd0, DIFF}, 32'h0000000E);
      check_eq("hold_bout", {31'd0, B_OUT}, 32'd1);
      run_op(4'd5, 4'd5, 1'b1, 0);
      tick();
      run_op(4'd15, 4'd0, 1'b1, 0);
      tick();

      run_op(4'd10, 4'd15, 1'b0, 2);
      run_op(4'd9, 4'd2, 1'b0, 0);
      tick();

      // Reset mid-RUN, with a start in the same cycle that must be dropped
      launch(4'd12, 4'd3, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      start = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      start = 1'b0;
      check_eq("abort_ready", {31'd0, ready}, 32'd1);
      check_eq("abort_diff", {28'd0, DIFF}, 32'd0);
      check_eq("abort_bout", {31'd0, B_OUT}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         check_eq("abort_no_done", {31'd0, done}, 32'd0);
         tick();
      end

      // Exhaustive sweep, back-to-back through DONE
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               run_op(4'(a), 4'(b), 1'(c), 0);
            end
         end
      end
      tick();
      tick();
      check_eq("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end

endmodule
